// File: rtl/axis_width_downsizer.sv
// ---------------------------------------------------------------------------
// axis_width_downsizer
//
// Splits each IN_W-bit AXI-Stream word into R = IN_W/OUT_W narrower beats.
// Full ready/valid handshaking is provided on both sides. Back-to-back words
// stream with no bubble, because the next word is accepted during the cycle
// that moves the last slice out.
//
// Optional feature macro: AXIS_DWN_TLAST_EN
//   defined   : m_axis_tlast marks every PKT_BEATS-th output beat.
//   undefined : m_axis_tlast is tied to 0 and no packet counter is built.
//
// Ports
//   pl_clk        in   clock, rising edge
//   rst           in   asynchronous reset, active low
//   msb_first     in   slice order, latched with each accepted input word
//                      (0 = bits [OUT_W-1:0] are sent first)
//   s_axis_tdata  in   IN_W input word
//   s_axis_tvalid in   input valid
//   s_axis_tready out  input ready (combinational from m_axis_tready and rst)
//   m_axis_tdata  out  OUT_W output beat (registered)
//   m_axis_tvalid out  output valid (registered)
//   m_axis_tready in   output ready
//   m_axis_tlast  out  last beat of a packet (registered, or tied to 0)
// ---------------------------------------------------------------------------
module axis_width_downsizer #(
   parameter int IN_W      = 128,
   parameter int OUT_W     = 32,
   parameter int PKT_BEATS = 256
) (
   input  logic             pl_clk,
   input  logic             rst,
   input  logic             msb_first,
   input  logic [IN_W-1:0]  s_axis_tdata,
   input  logic             s_axis_tvalid,
   output logic             s_axis_tready,
   output logic [OUT_W-1:0] m_axis_tdata,
   output logic             m_axis_tvalid,
   input  logic             m_axis_tready,
   output logic             m_axis_tlast
);

   localparam int R  = IN_W / OUT_W;
   localparam int IW = (R > 1) ? $clog2(R) : 1;

   generate
      if ((IN_W % OUT_W) != 0 || R < 2) begin : g_bad_width
         $error("axis_width_downsizer: IN_W must be a multiple of OUT_W with IN_W/OUT_W >= 2");
      end
      if (PKT_BEATS < 1) begin : g_bad_pkt
         $error("axis_width_downsizer: PKT_BEATS must be >= 1");
      end
   endgenerate

   typedef enum logic {IDLE, SEND} state_e;

   state_e              state_q, state_d;
   logic [IN_W-1:0]     buf_q, buf_d;
   logic [IW-1:0]       idx_q, idx_d;
   logic                ord_q, ord_d;
   logic [OUT_W-1:0]    tdata_q, tdata_d;

   logic                last_slice;
   logic                in_xfer, out_xfer;
   logic                load, advance;

   // Next word viewed as R slices; the slice to present is picked from the
   // *next* buf/ord/idx so the registered output already holds it.
   logic [R-1:0][OUT_W-1:0] nxt_slices;
   logic [IW-1:0]           nxt_k;

   assign last_slice    = (idx_q == IW'(R-1));
   assign out_xfer      = (state_q == SEND) & m_axis_tready;

   // Ready is high when idle, or when the final slice leaves this cycle so
   // the next word can slot in without a bubble. Held low during reset.
   assign s_axis_tready = rst & ((state_q == IDLE) |
                                 ((state_q == SEND) & last_slice & m_axis_tready));
   assign in_xfer       = s_axis_tvalid & s_axis_tready;

   always_comb begin
      state_d = state_q;
      buf_d   = buf_q;
      idx_d   = idx_q;
      ord_d   = ord_q;
      load    = 1'b0;
      advance = 1'b0;
      case (state_q)
         IDLE: begin
            if (in_xfer) load = 1'b1;
         end
         SEND: begin
            if (out_xfer) begin
               if (!last_slice) begin
                  idx_d   = idx_q + IW'(1);
                  advance = 1'b1;
               end else if (in_xfer) begin
                  load = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      if (load) begin
         buf_d   = s_axis_tdata;
         ord_d   = msb_first;
         idx_d   = '0;
         state_d = SEND;
      end
   end

   assign nxt_slices = buf_d;
   assign nxt_k      = ord_d ? (IW'(R-1) - idx_d) : idx_d;

   always_comb begin
      tdata_d = tdata_q;
      if (load || advance) tdata_d = nxt_slices[nxt_k];
   end

   always_ff @(posedge pl_clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         buf_q   <= '0;
         idx_q   <= '0;
         ord_q   <= 1'b0;
         tdata_q <= '0;
      end else begin
         state_q <= state_d;
         buf_q   <= buf_d;
         idx_q   <= idx_d;
         ord_q   <= ord_d;
         tdata_q <= tdata_d;
      end
   end

   assign m_axis_tvalid = (state_q == SEND);
   assign m_axis_tdata  = tdata_q;

`ifdef AXIS_DWN_TLAST_EN
   localparam int PW = (PKT_BEATS > 1) ? $clog2(PKT_BEATS) : 1;

   logic [PW-1:0] pkt_cnt_q, pkt_cnt_d;
   logic          tlast_q, tlast_d;

   // Counts output beats independent of word boundaries, so packets may
   // end mid-word when PKT_BEATS is not a multiple of R.
   always_comb begin
      pkt_cnt_d = pkt_cnt_q;
      if (out_xfer) begin
         if (pkt_cnt_q == PW'(PKT_BEATS-1)) pkt_cnt_d = '0;
         else                               pkt_cnt_d = pkt_cnt_q + PW'(1);
      end
      tlast_d = (state_d == SEND) & (pkt_cnt_d == PW'(PKT_BEATS-1));
   end

   always_ff @(posedge pl_clk or negedge rst) begin
      if (!rst) begin
         pkt_cnt_q <= '0;
         tlast_q   <= 1'b0;
      end else begin
         pkt_cnt_q <= pkt_cnt_d;
         tlast_q   <= tlast_d;
      end
   end

   assign m_axis_tlast = tlast_q;
`else
   assign m_axis_tlast = 1'b0;
`endif

endmodule
